// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regfile_pkg
// Purpose : Shared types and constants for the register-file write-back path.
// Revision: 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int WB_XLEN    = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t          rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

  // x0 is hard-wired zero: a request to it is consumed but never written.
  function automatic logic rd_writes(input reg_addr_t rd);
    return (rd != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Purpose : Single-clock FIFO with full/empty flags and an occupancy count.
//           DEPTH must be a power of two and at least 2. Push when full and
//           pop when empty are ignored.
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wptr;
  logic [c_AW:0]    r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_count   = r_wptr - r_rptr;
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (o_count == (c_AW+1)'(DEPTH));
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_data    = r_mem[r_rptr[c_AW-1:0]];

  // Pointer update; reset returns the FIFO to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[c_AW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module  : regfile_writeback
// Purpose : Owns the register-file write port. Merges single-cycle ALU
//           results with in-order load returns (ALU has priority), and keeps
//           a per-register busy scoreboard for decode hazard stalls.
//           Optional macro REGFILE_WB_FWD_EN: clears busy on the edge rf_we
//           rises and adds fwd_hit1/fwd_hit2/fwd_data forwarding outputs.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 4,
  parameter int RB_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_alu_valid,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]       i_alu_data,
  input  logic                  i_ld_issue,
  input  logic [REG_ADDR_W-1:0] i_ld_rd,
  output logic                  o_ld_issue_rdy,
  input  logic                  i_ld_rsp_valid,
  input  logic [XLEN-1:0]       i_ld_rsp_data,
  output logic                  o_ld_rsp_rdy,
  input  logic [REG_ADDR_W-1:0] i_dec_rs1,
  input  logic [REG_ADDR_W-1:0] i_dec_rs2,
  input  logic [REG_ADDR_W-1:0] i_dec_rd,
  output logic                  o_dec_hazard,
  output logic                  o_rf_we,
  output logic [REG_ADDR_W-1:0] o_rf_a3,
  output logic [XLEN-1:0]       o_rf_wd3
`ifdef REGFILE_WB_FWD_EN
  ,
  output logic                  o_fwd_hit1,
  output logic                  o_fwd_hit2,
  output logic [XLEN-1:0]       o_fwd_data
`endif
);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [NUM_REGS-1:0]        r_busy;
  logic [NUM_REGS-1:0]        w_busy_nxt;
  logic                       r_we;
  logic [REG_ADDR_W-1:0]      r_a3;
  logic [XLEN-1:0]            r_wd3;
`ifndef REGFILE_WB_FWD_EN
  logic                       r_ld;
`endif

  logic                       w_tag_push;
  logic                       w_tag_full;
  logic                       w_tag_empty;
  logic [REG_ADDR_W-1:0]      w_tag_head;
  logic [$clog2(LQ_DEPTH):0]  w_tag_cnt;

  logic                       w_rsp_push;
  logic                       w_rsp_full;
  logic                       w_rsp_empty;
  logic [XLEN-1:0]            w_rsp_head;
  logic [$clog2(RB_DEPTH):0]  w_rsp_cnt;
  logic                       w_has_tag;

  logic                       w_ld_pop;
  logic                       w_win_v;
  logic [REG_ADDR_W-1:0]      w_win_rd;
  logic [XLEN-1:0]            w_win_data;
  logic                       w_win_wr;

  logic                       w_set_en;
  logic                       w_clr_en;
  logic [REG_ADDR_W-1:0]      w_clr_rd;

  // --------------------------------------------------------------------------
  // Load tag and response queues
  // --------------------------------------------------------------------------
  // Both ready outputs are forced low while reset is held.
  assign o_ld_issue_rdy = rst_n & ~w_tag_full;
  assign o_ld_rsp_rdy   = rst_n & ~w_rsp_full;
  assign w_tag_push     = i_ld_issue & o_ld_issue_rdy;

  // A response is only kept if some issued tag is still waiting for data;
  // anything else has no destination and is dropped.
  assign w_has_tag  = (32'(w_tag_cnt) > 32'(w_rsp_cnt));
  assign w_rsp_push = i_ld_rsp_valid & o_ld_rsp_rdy & w_has_tag;

  sync_fifo #(
    .WIDTH (REG_ADDR_W),
    .DEPTH (LQ_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_tag_push),
    .i_data  (i_ld_rd),
    .i_pop   (w_ld_pop),
    .o_data  (w_tag_head),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty),
    .o_count (w_tag_cnt)
  );

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (RB_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rsp_push),
    .i_data  (i_ld_rsp_data),
    .i_pop   (w_ld_pop),
    .o_data  (w_rsp_head),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty),
    .o_count (w_rsp_cnt)
  );

  // --------------------------------------------------------------------------
  // Write-port arbitration: ALU first, otherwise the oldest buffered load.
  // The response-buffer head always pairs with the tag-FIFO head.
  // --------------------------------------------------------------------------
  assign w_ld_pop   = ~i_alu_valid & ~w_rsp_empty;
  assign w_win_v    = i_alu_valid | w_ld_pop;
  assign w_win_rd   = i_alu_valid ? i_alu_rd   : w_tag_head;
  assign w_win_data = i_alu_valid ? i_alu_data : w_rsp_head;
  assign w_win_wr   = w_win_v & rd_writes(w_win_rd);

  // Register the winner onto the write port; x0 targets are consumed silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we  <= 1'b0;
      r_a3  <= '0;
      r_wd3 <= '0;
`ifndef REGFILE_WB_FWD_EN
      r_ld  <= 1'b0;
`endif
    end else begin
      r_we <= w_win_wr;
`ifndef REGFILE_WB_FWD_EN
      r_ld <= w_ld_pop & w_win_wr;
`endif
      if (w_win_wr) begin
        r_a3  <= w_win_rd;
        r_wd3 <= w_win_data;
      end
    end
  end

  assign o_rf_we  = r_we;
  assign o_rf_a3  = r_a3;
  assign o_rf_wd3 = r_wd3;

  // --------------------------------------------------------------------------
  // Busy scoreboard
  // --------------------------------------------------------------------------
  assign w_set_en = w_tag_push & rd_writes(i_ld_rd);

`ifdef REGFILE_WB_FWD_EN
  // With forwarding, decode can take the value off the write port, so the
  // register frees up as soon as the load wins arbitration.
  assign w_clr_en = w_ld_pop & rd_writes(w_tag_head);
  assign w_clr_rd = w_tag_head;
`else
  // Without forwarding, the register frees up once the rf_we cycle is over,
  // because the same-negedge read still returns the old value.
  assign w_clr_en = r_we & r_ld;
  assign w_clr_rd = r_a3;
`endif

  // Next busy vector: clear is applied first so a same-edge set wins.
  always_comb begin
    w_busy_nxt = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      w_busy_nxt[i] = (r_busy[i] & ~(w_clr_en & (w_clr_rd == REG_ADDR_W'(i))))
                    | (w_set_en & (i_ld_rd == REG_ADDR_W'(i)));
    end
  end

  // Scoreboard state; reset discards all outstanding loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign o_dec_hazard = (rd_writes(i_dec_rs1) & r_busy[i_dec_rs1])
                      | (rd_writes(i_dec_rs2) & r_busy[i_dec_rs2])
                      | (rd_writes(i_dec_rd)  & r_busy[i_dec_rd]);

`ifdef REGFILE_WB_FWD_EN
  // --------------------------------------------------------------------------
  // Forwarding of the value currently on the write port
  // --------------------------------------------------------------------------
  assign o_fwd_hit1 = r_we & rd_writes(r_a3) & (r_a3 == i_dec_rs1);
  assign o_fwd_hit2 = r_we & rd_writes(r_a3) & (r_a3 == i_dec_rs2);
  assign o_fwd_data = r_wd3;
`endif

  // --------------------------------------------------------------------------
  // Protocol checks on the surrounding pipeline
  // --------------------------------------------------------------------------
  a_issue_to_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (w_tag_push && rd_writes(i_ld_rd)) |-> !r_busy[i_ld_rd])
    else $error("regfile_writeback: load issued to busy register x%0d", i_ld_rd);

  a_rsp_no_tag: assert property (@(posedge clk) disable iff (!rst_n)
    i_ld_rsp_valid |-> !w_tag_empty)
    else $error("regfile_writeback: load response with no outstanding tag");

endmodule
`default_nettype wire
